// File: rtl/fp8_pkg.sv
// Shared types and constants for the fp8 adder issue stage.
// Field layout is {sign, exp[2:0], mant[3:0]}.
package fp8_pkg;

    localparam int FP8_W    = 8;
    localparam int SIGN_BIT = 7;
    localparam int EXP_MSB  = 6;
    localparam int EXP_LSB  = 4;
    localparam int MANT_MSB = 3;
    localparam int MANT_LSB = 0;

    localparam int EXP_W  = EXP_MSB - EXP_LSB + 1;
    localparam int MANT_W = MANT_MSB - MANT_LSB + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    // Operand patterns for each stable level of x.
    localparam logic [FP8_W-1:0] OP_A_X0 = 8'h4F;
    localparam logic [FP8_W-1:0] OP_A_X1 = 8'hB0;
    localparam logic [FP8_W-1:0] OP_B_X0 = 8'hCE;
    localparam logic [FP8_W-1:0] OP_B_X1 = 8'h31;

    function automatic logic [FP8_W-1:0] fp8_pack(
        input logic              s,
        input logic [EXP_W-1:0]  e,
        input logic [MANT_W-1:0] m
    );
        logic [FP8_W-1:0] w;
        w                     = '0;
        w[SIGN_BIT]           = s;
        w[EXP_MSB:EXP_LSB]    = e;
        w[MANT_MSB:MANT_LSB]  = m;
        return w;
    endfunction

    function automatic logic [FP8_W-1:0] op_a(input logic x);
        return fp8_pack(x, {~x, x, x}, {4{~x}});
    endfunction

    function automatic logic [FP8_W-1:0] op_b(input logic x);
        return fp8_pack(~x, {~x, x, x}, {~x, ~x, ~x, x});
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Synchroniser plus debouncer for the operand-select switch.
// Emits a one-cycle strobe together with each accepted level change.
module sync_debounce
    import fp8_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic edge_strobe
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   strobe_q, strobe_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Shift din through the chain; count cycles the synced value disagrees.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], din};
        cnt_d    = '0;
        level_d  = level_q;
        strobe_d = 1'b0;
        if (synced != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d  = synced;
                strobe_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            strobe_q <= strobe_d;
        end
    end

    assign level       = level_q;
    assign edge_strobe = strobe_q;

endmodule

// File: rtl/fp8_add_sequencer.sv
// Issue stage for the fp8 adder: builds a/b from the debounced
// switch, pulses start, waits for valid under a watchdog.
module fp8_add_sequencer
    import fp8_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
    output logic [7:0] a,
    output logic [7:0] b,
    output logic       start,
    input  logic [7:0] adder_sum,
    input  logic       adder_valid,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       busy,
    output logic       timeout_err,
    output logic       dropped
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic level;
    logic strobe;

    state_e             state_q, state_d;
    logic               pending_q, pending_d;
    logic               dropped_q, dropped_d;
    logic               toerr_q, toerr_d;
    logic               rv_q, rv_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [FP8_W-1:0]   a_q, a_d;
    logic [FP8_W-1:0]   b_q, b_d;
    logic [FP8_W-1:0]   res_q, res_d;
    logic               busy_st;

    sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync (
        .clk         (clk),
        .reset       (reset),
        .din         (x),
        .level       (level),
        .edge_strobe (strobe)
    );

    // Next-state: issue sequencing, pending/drop tracking, watchdog.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        dropped_d = dropped_q;
        toerr_d   = toerr_q;
        rv_d      = 1'b0;
        wd_d      = wd_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        busy_st   = (state_q != S_IDLE);

        // Only one edge can be queued behind an operation.
        if (busy_st && strobe) begin
            if (pending_q) begin
                dropped_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (strobe || pending_q) begin
                    a_d       = op_a(level);
                    b_d       = op_b(level);
                    pending_d = 1'b0;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + 1'b1;
                if (adder_valid) begin
                    res_d   = adder_sum;
                    rv_d    = 1'b1;
                    state_d = S_IDLE;
                end else if (wd_q == WD_LAST) begin
                    toerr_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pending_q <= 1'b0;
            dropped_q <= 1'b0;
            toerr_q   <= 1'b0;
            rv_q      <= 1'b0;
            wd_q      <= '0;
            a_q       <= OP_A_X0;
            b_q       <= OP_B_X0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            dropped_q <= dropped_d;
            toerr_q   <= toerr_d;
            rv_q      <= rv_d;
            wd_q      <= wd_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
        end
    end

    // start is masked by reset so no issue leaks out on a reset cycle.
    assign start        = (state_q == S_ISSUE) && !reset;
    assign busy         = busy_st;
    assign a            = a_q;
    assign b            = b_q;
    assign result       = res_q;
    assign result_valid = rv_q;
    assign timeout_err  = toerr_q;
    assign dropped      = dropped_q;

endmodule

// File: tb/tb_fp8_add_sequencer.sv
// Bench for fp8_add_sequencer: directed scenarios plus random
// stimulus, every cycle checked against a behavioural model.
module tb_fp8_add_sequencer;
    import fp8_pkg::*;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int TMO  = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       x;
    logic [7:0] a, b, adder_sum, result;
    logic       start, adder_valid, result_valid;
    logic       busy, timeout_err, dropped;

    always #5 clk = ~clk;

    fp8_add_sequencer #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .x            (x),
        .a            (a),
        .b            (b),
        .start        (start),
        .adder_sum    (adder_sum),
        .adder_valid  (adder_valid),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .timeout_err  (timeout_err),
        .dropped      (dropped)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_starts = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t got=%0h exp=%0h",
                     tag, $time, got, exp);
        end
    endtask

    // Reference model: sync is a delay line, debounce is "the last
    // DEB synced samples all disagree with the level", and the
    // sequencer is a phase (0 idle, 1 issue, 2 wait) with a counter.
    bit         m_sq[$];
    bit         m_hist[$];
    bit         m_lvl, m_strobe, m_pend, m_drop, m_toerr, m_rv;
    int         m_phase, m_wcnt;
    logic [7:0] m_a, m_b, m_res;

    task automatic m_rst();
        m_sq.delete();
        m_hist.delete();
        repeat (SYNC) m_sq.push_back(1'b0);
        repeat (DEB) m_hist.push_back(1'b0);
        m_lvl = 0; m_strobe = 0; m_pend = 0;
        m_drop = 0; m_toerr = 0; m_rv = 0;
        m_phase = 0; m_wcnt = 0;
        m_a = OP_A_X0; m_b = OP_B_X0; m_res = 8'h00;
    endtask

    task automatic m_step();
        bit s, diff;
        if (reset) begin
            m_rst();
            return;
        end
        m_rv = 0;
        if (m_phase == 0) begin
            if (m_strobe || m_pend) begin
                m_a = m_lvl ? OP_A_X1 : OP_A_X0;
                m_b = m_lvl ? OP_B_X1 : OP_B_X0;
                m_pend = 0;
                m_phase = 1;
            end
        end else begin
            if (m_strobe) begin
                if (m_pend) m_drop = 1;
                else m_pend = 1;
            end
            if (m_phase == 1) begin
                m_phase = 2;
                m_wcnt = 0;
            end else begin
                m_wcnt++;
                if (adder_valid) begin
                    m_res = adder_sum;
                    m_rv = 1;
                    m_phase = 0;
                end else if (m_wcnt == TMO) begin
                    m_toerr = 1;
                    m_phase = 0;
                end
            end
        end
        s = m_sq.pop_front();
        m_sq.push_back(x);
        void'(m_hist.pop_front());
        m_hist.push_back(s);
        diff = 1;
        foreach (m_hist[i]) if (m_hist[i] == m_lvl) diff = 0;
        m_strobe = diff;
        if (diff) m_lvl = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_step();
        chk("start", 32'(start), 32'(m_phase == 1));
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("rvalid", 32'(result_valid), 32'(m_rv));
        chk("result", 32'(result), 32'(m_res));
        chk("a", 32'(a), 32'(m_a));
        chk("b", 32'(b), 32'(m_b));
        chk("toerr", 32'(timeout_err), 32'(m_toerr));
        chk("dropped", 32'(dropped), 32'(m_drop));
        if (start) n_starts++;
    endtask

    initial begin
        int  first, rvc, hold;
        bit  got;

        reset = 1'b1; x = 1'b0;
        adder_valid = 1'b0; adder_sum = 8'h00;
        m_rst();
        tick(); tick();
        reset = 1'b0;

        // 1: idle with x low.
        n_starts = 0;
        repeat (50) tick();
        chk("t1_starts", 32'(n_starts), 32'd0);
        chk("t1_a", 32'(a), 32'h4F);
        chk("t1_b", 32'(b), 32'hCE);
        chk("t1_flags", 32'({timeout_err, dropped}), 32'd0);

        // 2: rising edge, adder answers after start.
        x = 1'b1; first = 0; rvc = 0;
        for (int t = 1; t <= 20; t++) begin
            adder_valid = (first != 0) && (t == first + 4);
            adder_sum = 8'h42;
            tick();
            if (start && first == 0) first = t;
            if (result_valid) rvc++;
        end
        adder_valid = 1'b0;
        chk("t2_latency", 32'(first), 32'd7);
        chk("t2_a", 32'(a), 32'hB0);
        chk("t2_b", 32'(b), 32'h31);
        chk("t2_result", 32'(result), 32'h42);
        chk("t2_rv_pulses", 32'(rvc), 32'd1);

        // 4: adder never answers.
        x = 1'b0;
        repeat (30) tick();
        chk("t4_toerr", 32'(timeout_err), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_result", 32'(result), 32'h42);

        // 3: short glitch is rejected.
        n_starts = 0;
        x = 1'b1; tick(); tick();
        x = 1'b0;
        repeat (20) tick();
        chk("t3_starts", 32'(n_starts), 32'd0);
        chk("t3_a", 32'(a), 32'h4F);

        // 4b: next edge still issues after a timeout.
        x = 1'b1;
        repeat (12) tick();
        chk("t4_reissue", 32'(n_starts), 32'd1);
        repeat (20) tick();

        // 5: two edges accepted during WAIT.
        n_starts = 0; got = 0;
        x = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = start;
        end
        chk("t5_issue", 32'(got), 32'd1);
        x = 1'b1;
        repeat (7) tick();
        x = 1'b0;
        repeat (7) tick();
        chk("t5_dropped", 32'(dropped), 32'd1);
        repeat (30) tick();
        chk("t5_starts", 32'(n_starts), 32'd2);
        chk("t5_a", 32'(a), 32'h4F);

        // 6: reset during WAIT, valid right after.
        reset = 1'b1; tick(); reset = 1'b0;
        x = 1'b1; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = start;
        end
        chk("t6_issue", 32'(got), 32'd1);
        tick(); tick();
        reset = 1'b1; tick(); reset = 1'b0;
        adder_valid = 1'b1; adder_sum = 8'h99;
        tick(); tick();
        adder_valid = 1'b0;
        chk("t6_result", 32'(result), 32'h00);
        chk("t6_rv", 32'(result_valid), 32'd0);
        chk("t6_flags", 32'({timeout_err, dropped}), 32'd0);
        chk("t6_a", 32'(a), 32'h4F);
        chk("t6_b", 32'(b), 32'hCE);

        // Random: switch bounce, random adder, rare resets.
        hold = 0;
        repeat (4000) begin
            if (hold == 0) begin
                x = ~x;
                hold = $urandom_range(12, 1);
            end
            hold--;
            adder_valid = ($urandom_range(7) == 0);
            adder_sum = 8'($urandom);
            reset = ($urandom_range(299) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
